// File: rtl/memory_unit.sv
// SAP-1 memory stage: MAR, MDR and a 16x8 RAM.
// The RAM is read combinationally onto the shared bus and written from the
// MDR under control_block strobes. A valid/ready loader fills the RAM from
// the chip pins before the CPU runs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | CPU owns the block; control strobes update MAR/MDR/RAM
// ST_PROG | loader owns the RAM; bytes stream into RAM[counter]
// ST_DONE | all locations loaded; waits for prog_mode to drop
module memory_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_addr_load_n,
  input  logic              mar_mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PROG = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              rdy_q, done_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Next-state, register-update and single RAM write-port selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    wr_en   = 1'b0;
    wr_addr = mar_q;
    wr_data = mdr_q;
    case (state_q)
      ST_RUN: begin
        if (!mar_addr_load_n) mar_d = bus_in[ADDR_W-1:0];
        if (!mar_mem_load_n)  mdr_d = bus_in;
        // Write uses pre-edge MAR and MDR even if they load this cycle
        if (!ram_load_n)      wr_en = 1'b1;
        if (prog_mode) begin
          state_d = ST_PROG;
          cnt_d   = '0;
        end
      end
      ST_PROG: begin
        // prog_ready is always high here, so a valid byte is a transfer
        if (prog_valid) begin
          wr_en   = 1'b1;
          wr_addr = cnt_q;
          wr_data = prog_data;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_DONE;
        end
        if (!prog_mode) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (!prog_mode) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Loader FSM plus MAR/MDR; handshake flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdy_q   <= (state_d == ST_PROG);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // RAM array; cleared on reset so a partial program never survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // rst_n gates the bus driver because the state flop reads RUN during reset
  assign bus_oe     = rst_n & (state_q == ST_RUN) & ~ram_en_n;
  assign bus_out    = bus_oe ? mem_q[mar_q] : '0;
  assign prog_ready = rdy_q;
  assign prog_done  = done_q;

endmodule
